hdmi_axi_rd_master: RTL and testbench
=====================================

HDMI_AXI_RD_MASTER -- requirements
Module: hdmi_axi_rd_master

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: byte offset added to every request address.
REQ-002 Parameter MAX_BEATS, default 256: upper limit on beats per burst (AXI4 INCR limit).
REQ-003 clk_vga  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 kick  in  1  request strobe from the address generator; held high until busy is seen.
REQ-006 read_addr  in  32  request byte address; stable while kick is high.
REQ-007 read_num  in  32  request length in 32-bit beats.
REQ-008 busy  out  1  registered; high while a request is accepted or in progress.
REQ-009 m_axi_araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1  AXI4 read-address channel.
REQ-010 m_axi_arready  in  1  AXI4 read-address ready.
REQ-011 m_axi_rdata/rresp/rlast/rvalid  in  32/2/1/1  AXI4 read-data channel.
REQ-012 m_axi_rready  out  1  AXI4 read-data ready.
REQ-013 pix_data/pix_valid  out  32/1  registered pixel stream to the line FIFO.
REQ-014 pix_ready  in  1  line FIFO can accept a pixel.
REQ-015 err_resp/err_last  out  1/1  sticky status flags: bad RRESP, and RLAST/beat-count mismatch.

Function
REQ-016 The FSM SHALL have three states: IDLE, ADDR and DATA.
- IDLE->ADDR on kick=1.
- ADDR->DATA on arvalid&&arready.
- DATA->IDLE on acceptance of the final beat.
REQ-017 busy SHALL be 0 in IDLE and SHALL go high at the clock edge where kick is sampled high in IDLE, giving exactly one cycle of latency.
REQ-018 busy SHALL stay high through ADDR and DATA and SHALL fall at the edge where the final beat is accepted.
REQ-019 kick SHALL be ignored while busy=1.
REQ-020 On kick acceptance, the block SHALL capture the following into registers:
- araddr = ADDR_BASE + read_addr, modulo 2^32;
- len = read_num.
REQ-021 arlen SHALL be len-1.
- read_num > MAX_BEATS: clamp len to MAX_BEATS and set err_last.
- read_num = 0: issue no AXI transaction, hold busy high for exactly one cycle, return to IDLE, set err_last.
REQ-022 arsize SHALL be 3'b010 and arburst SHALL be 2'b01 (INCR) at all times.
REQ-023 arvalid SHALL rise on the cycle after kick acceptance and SHALL hold, with araddr/arlen stable, until arready=1.
- arready already high when arvalid rises completes the handshake in that cycle.
REQ-024 rready SHALL be 0 outside DATA.
- In DATA: rready = ~pix_valid | pix_ready (one-entry output register).
REQ-025 On a beat accepted (rvalid&&rready), the block SHALL:
- load pix_data with rdata;
- set pix_valid to 1 on the next cycle;
- increment the 9-bit beat counter.
REQ-026 pix_valid SHALL clear on pix_ready unless a new beat is loaded in the same cycle; pix_data SHALL hold while pix_valid&&~pix_ready.
REQ-027 The final beat SHALL be the beat where count reaches len; the block SHALL return to IDLE on it regardless of rlast.
- rlast high on an earlier beat: set err_last.
- rlast low on the final beat: set err_last.
REQ-028 Any accepted beat with rresp != 2'b00 SHALL set err_resp; the data SHALL still be forwarded.
REQ-029 err flags SHALL clear only on rst.
REQ-030 A new kick SHALL be accepted on the first cycle busy=0, including the cycle after burst completion.
REQ-031 A pending pix_valid SHALL drain independently of the FSM state.

Reset
REQ-032 rst=1 SHALL force the following on the next edge:
- state=IDLE;
- busy=0, arvalid=0, rready=0, pix_valid=0;
- beat counter=0, err_resp=0, err_last=0;
- araddr, arlen and pix_data to 0.
REQ-033 rst mid-burst SHALL abandon the burst without completing it; rst SHALL be asserted together with the interconnect reset.

Verification
REQ-034 Single request: kick with read_addr=0x100, read_num=64; arready immediate; rvalid continuous; pix_ready=1.
- busy high at cycle+1.
- araddr=0x100, arlen=63.
- 64 pixels in order; busy low after beat 64.
- Both error flags 0.
REQ-035 Back-pressure: same request with pix_ready toggling 1/0 each cycle.
- No pixel lost or duplicated.
- pix_data stable while stalled.
- rready deasserted appropriately.
REQ-036 Slow arready: arready low for 5 cycles.
- arvalid held with araddr/arlen unchanged.
- Handshake completes on cycle 6.
- A kick held during this time is not re-accepted.
REQ-037 Boundary lengths:
- read_num=0: one-cycle busy pulse, no arvalid, err_last=1.
- read_num=300: arlen=255, err_last=1.
REQ-038 Protocol errors: rresp=2'b10 on beat 3 and rlast on beat 60 of 64.
- err_resp=1 and err_last=1.
- All 64 beats forwarded; FSM returns to IDLE.
REQ-039 Reset mid-burst at beat 20: next cycle busy=0, pix_valid=0, flags 0; a new kick is accepted normally afterwards.

Source files
------------

// File: rtl/hdmi_axi_rd_master.sv
// -----------------------------------------------------------------------------
// hdmi_axi_rd_master
//
// Purpose:
//   Turns a framebuffer read request (byte address + length in 32-bit beats)
//   into one AXI4 INCR read burst. The returned beats are forwarded into a
//   pixel stream that feeds the HDMI line FIFO. A one-entry output register
//   sits between the AXI R channel and the pixel stream. It provides
//   back-pressure through rready and drains on its own, in any FSM state.
//
// Parameters:
//   ADDR_BASE  byte offset added to every request address (wraps at 2^32)
//   MAX_BEATS  largest burst issued; longer requests are clamped (<= 256)
//
// Ports:
//   clk_vga            in   sole clock, rising edge
//   rst                in   synchronous active-high reset
//   kick               in   request strobe, held until busy is seen
//   read_addr[31:0]    in   request byte address
//   read_num[31:0]     in   request length in 32-bit beats
//   busy               out  request accepted or in progress
//   m_axi_ar*          out  AXI4 read-address channel (arready is an input)
//   m_axi_r*           in   AXI4 read-data channel (rready is an output)
//   pix_data[31:0]     out  pixel word to the line FIFO
//   pix_valid          out  pix_data holds a pixel
//   pix_ready          in   line FIFO accepts the pixel
//   err_resp           out  sticky: a beat returned a non-OKAY RRESP
//   err_last           out  sticky: RLAST disagreed with the beat count, or the
//                           request length was zero or was clamped
// -----------------------------------------------------------------------------
module hdmi_axi_rd_master #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic        clk_vga,
    input  logic        rst,

    input  logic        kick,
    input  logic [31:0] read_addr,
    input  logic [31:0] read_num,
    output logic        busy,

    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,

    output logic        err_resp,
    output logic        err_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // The beat counter is 9 bits wide so that a full 256-beat burst is
    // representable.
    localparam logic [8:0]  MAX_LEN = 9'(MAX_BEATS);
    localparam logic [31:0] MAX_NUM = 32'(MAX_BEATS);

    // Registered state
    state_t      state_q;
    logic        busy_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        arvalid_q;
    logic [8:0]  len_q;
    logic [8:0]  cnt_q;
    logic        zero_q;
    logic [31:0] pix_data_q;
    logic        pix_valid_q;
    logic        err_resp_q;
    logic        err_last_q;

    // Combinational next values / decodes
    logic        zero_d;
    logic        clamp_d;
    logic [8:0]  len_d;
    logic [7:0]  arlen_d;
    logic        rready_d;
    logic        beat_d;
    logic [8:0]  cnt_d;
    logic        final_d;

    always_comb begin
        zero_d   = (read_num == 32'd0);
        clamp_d  = (read_num > MAX_NUM);
        // When not clamped, read_num is at most MAX_BEATS and fits in 9 bits.
        len_d    = clamp_d ? MAX_LEN : read_num[8:0];
        arlen_d  = zero_d ? 8'd0 : 8'(len_d - 9'd1);
        // The output register accepts a new beat when it is empty, or when it
        // is being emptied in this same cycle.
        rready_d = (state_q == DATA) && (!pix_valid_q || pix_ready);
        beat_d   = rready_d && m_axi_rvalid;
        cnt_d    = cnt_q + 9'd1;
        // The burst ends on the beat count alone. RLAST is only checked.
        final_d  = (cnt_d == len_q);
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            araddr_q    <= 32'd0;
            arlen_q     <= 8'd0;
            arvalid_q   <= 1'b0;
            len_q       <= 9'd0;
            cnt_q       <= 9'd0;
            zero_q      <= 1'b0;
            pix_data_q  <= 32'd0;
            pix_valid_q <= 1'b0;
            err_resp_q  <= 1'b0;
            err_last_q  <= 1'b0;
        end else begin
            // The pixel output register drains independently of the FSM. A
            // pending pixel therefore still leaves after the burst has ended.
            if (beat_d) begin
                pix_data_q  <= m_axi_rdata;
                pix_valid_q <= 1'b1;
            end else if (pix_ready) begin
                pix_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (kick) begin
                        state_q   <= ADDR;
                        busy_q    <= 1'b1;
                        araddr_q  <= ADDR_BASE + read_addr;
                        arlen_q   <= arlen_d;
                        len_q     <= len_d;
                        cnt_q     <= 9'd0;
                        zero_q    <= zero_d;
                        // A zero-length request never reaches the bus.
                        arvalid_q <= !zero_d;
                        if (zero_d || clamp_d) begin
                            err_last_q <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    // A zero-length request spends exactly one busy cycle here.
                    if (zero_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        zero_q  <= 1'b0;
                    end else if (arvalid_q && m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (beat_d) begin
                        cnt_q <= cnt_d;
                        if (m_axi_rresp != 2'b00) begin
                            err_resp_q <= 1'b1;
                        end
                        if (final_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!m_axi_rlast) begin
                                err_last_q <= 1'b1;
                            end
                        end else if (m_axi_rlast) begin
                            err_last_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_d;
    assign pix_data      = pix_data_q;
    assign pix_valid     = pix_valid_q;
    assign err_resp      = err_resp_q;
    assign err_last      = err_last_q;

endmodule

// File: tb/tb_hdmi_axi_rd_master.sv
// -----------------------------------------------------------------------------
// tb_hdmi_axi_rd_master
//
// Purpose:
//   Self-checking bench for hdmi_axi_rd_master. An AXI slave model returns
//   beats whose data encodes the burst number and the beat index. Each
//   accepted beat pushes its expected pixel into a scoreboard queue. Each
//   pixel leaving the DUT is compared against the head of that queue.
// -----------------------------------------------------------------------------
module tb_hdmi_axi_rd_master;

    localparam logic [31:0] TB_BASE = 32'h1000_0000;

    logic        clk_vga = 1'b0;
    logic        rst = 1'b1;
    logic        kick = 1'b0;
    logic [31:0] read_addr = 32'd0;
    logic [31:0] read_num = 32'd0;
    logic        busy;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = 32'd0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        err_resp;
    logic        err_last;

    hdmi_axi_rd_master #(
        .ADDR_BASE(TB_BASE),
        .MAX_BEATS(256)
    ) dut (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .kick         (kick),
        .read_addr    (read_addr),
        .read_num     (read_num),
        .busy         (busy),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .err_resp     (err_resp),
        .err_last     (err_last)
    );

    always #5 clk_vga = ~clk_vga;

    int checks = 0;
    int failures = 0;

    // Scoreboard and bookkeeping
    logic [31:0] sb_q[$];
    int px_count = 0;
    int beats_acc = 0;
    int ar_hs_cnt = 0;
    int ar_high = 0;
    bit idle_next = 1'b0;

    // Slave model configuration and state
    int total = 0;
    int early_idx = -1;
    int err_idx = -1;
    bit final_rlast = 1'b1;
    int ar_delay = 0;
    bit pr_toggle = 1'b0;
    int ar_seen = 0;
    int beat_idx = 0;
    int burst_no = 0;
    bit r_active = 1'b0;
    bit r_hs_f = 1'b0;
    bit ar_hs_f = 1'b0;

    function automatic logic [31:0] mk(input int b, input int i);
        mk = (32'(b) << 24) | 32'h00C3_0000 | (32'(i) & 32'h0000_FFFF);
    endfunction

    // Monitor / scoreboard: sampled on the falling edge
    always @(negedge clk_vga) begin
        r_hs_f  = 1'b0;
        ar_hs_f = 1'b0;
        if (!rst) begin
            if (idle_next) begin
                idle_next = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_after_final_beat busy=%b expected=0", busy);
                end
            end
            if (pix_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL pix_unexpected pix_data=%h expected=no_pixel", pix_data);
                end else begin
                    if (pix_data !== sb_q[0]) begin
                        failures++;
                        $display("FAIL pix_data got=%h expected=%h", pix_data, sb_q[0]);
                    end
                    if (pix_ready) begin
                        void'(sb_q.pop_front());
                        px_count++;
                    end
                end
            end
            checks++;
            if (m_axi_rready && (!busy || (pix_valid && !pix_ready))) begin
                failures++;
                $display("FAIL rready got=1 expected=0 (busy=%b pix_valid=%b pix_ready=%b)",
                         busy, pix_valid, pix_ready);
            end
            if (m_axi_arvalid) ar_high++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs_f = 1'b1;
                ar_hs_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                r_hs_f = 1'b1;
                beats_acc++;
                sb_q.push_back(mk(burst_no, beat_idx));
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_during_burst busy=%b expected=1", busy);
                end
                if (beat_idx == total - 1) idle_next = 1'b1;
            end
        end
    end

    // AXI slave and pixel sink model: updates #1 after the rising edge
    always @(posedge clk_vga) begin
        #1;
        if (rst) begin
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'b00;
            m_axi_rdata   = 32'd0;
            m_axi_arready = 1'b0;
            r_active      = 1'b0;
            beat_idx      = 0;
            ar_seen       = 0;
            pix_ready     = 1'b1;
        end else begin
            if (r_hs_f) beat_idx++;
            if (ar_hs_f) begin
                r_active = 1'b1;
                beat_idx = 0;
                burst_no++;
            end
            if (r_active && beat_idx < total) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = mk(burst_no, beat_idx);
                m_axi_rresp  = (beat_idx == err_idx) ? 2'b10 : 2'b00;
                m_axi_rlast  = (beat_idx == early_idx) ||
                               (final_rlast && beat_idx == total - 1);
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                m_axi_rdata  = 32'd0;
                r_active     = 1'b0;
            end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_seen >= ar_delay);
                ar_seen++;
            end else begin
                m_axi_arready = 1'b0;
                ar_seen = 0;
            end
            pix_ready = pr_toggle ? ~pix_ready : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk_vga);
        #2;
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        kick = 1'b0;
        total = 0;
        early_idx = -1;
        err_idx = -1;
        final_rlast = 1'b1;
        ar_delay = 0;
        pr_toggle = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
        px_count = 0;
        beats_acc = 0;
        ar_hs_cnt = 0;
        ar_high = 0;
        idle_next = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk_vga);
            if (!busy && !pix_valid && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        checks++; if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b expected=0", m_axi_arvalid); end
        checks++; if (m_axi_rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b expected=0", m_axi_rready); end
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b expected=0", pix_valid); end
        checks++; if (err_resp !== 1'b0 || err_last !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b expected=00", err_resp, err_last); end
        checks++; if (m_axi_arsize !== 3'b010) begin failures++; $display("FAIL arsize got=%b expected=010", m_axi_arsize); end
        checks++; if (m_axi_arburst !== 2'b01) begin failures++; $display("FAIL arburst got=%b expected=01", m_axi_arburst); end
    endtask

    task automatic test_single(input bit toggle);
        bit ok;
        apply_reset();
        total = 64;
        pr_toggle = toggle;
        read_addr = 32'h0000_0100;
        read_num = 32'd64;
        kick = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_pre got=%b expected=0", busy); end
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_latency got=%b expected=1", busy); end
        kick = 1'b0;
        checks++; if (m_axi_arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid got=%b expected=1", m_axi_arvalid); end
        checks++; if (m_axi_araddr !== TB_BASE + 32'h100) begin failures++; $display("FAIL single_araddr got=%h expected=%h", m_axi_araddr, TB_BASE + 32'h100); end
        checks++; if (m_axi_arlen !== 8'd63) begin failures++; $display("FAIL single_arlen got=%0d expected=63", m_axi_arlen); end
        wait_idle(1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout done=0 expected=1"); end
        checks++; if (px_count !== 64) begin failures++; $display("FAIL single_pixels got=%0d expected=64", px_count); end
        checks++; if (err_resp !== 1'b0 || err_last !== 1'b0) begin failures++; $display("FAIL single_err got=%b%b expected=00", err_resp, err_last); end
        checks++; if (ar_hs_cnt !== 1) begin failures++; $display("FAIL single_ar_count got=%0d expected=1", ar_hs_cnt); end
    endtask

    task automatic test_slow_arready();
        bit ok;
        apply_reset();
        total = 16;
        ar_delay = 5;
        read_addr = 32'h0000_4000;
        read_num = 32'd16;
        kick = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== TB_BASE + 32'h4000 || m_axi_arlen !== 8'd15) begin
                failures++;
                $display("FAIL slow_ar_hold cycle=%0d got=%b/%h/%0d expected=1/%h/15",
                         i, m_axi_arvalid, m_axi_araddr, m_axi_arlen, TB_BASE + 32'h4000);
            end
            step();
        end
        checks++; if (m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL slow_ar_done got arvalid=%b busy=%b expected=0/1", m_axi_arvalid, busy); end
        kick = 1'b0;
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL slow_ar_timeout done=0 expected=1"); end
        checks++; if (ar_high !== 6) begin failures++; $display("FAIL slow_ar_cycles got=%0d expected=6", ar_high); end
        checks++; if (ar_hs_cnt !== 1) begin failures++; $display("FAIL slow_ar_count got=%0d expected=1", ar_hs_cnt); end
        checks++; if (px_count !== 16) begin failures++; $display("FAIL slow_ar_pixels got=%0d expected=16", px_count); end
    endtask

    task automatic test_boundary();
        bit ok;
        apply_reset();
        read_addr = 32'h0000_0800;
        read_num = 32'd0;
        kick = 1'b1;
        step();
        checks++; if (busy !== 1'b1 || m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL zero_first got busy=%b arvalid=%b expected=1/0", busy, m_axi_arvalid); end
        kick = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL zero_second got busy=%b arvalid=%b expected=0/0", busy, m_axi_arvalid); end
        checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL zero_err_last got=%b expected=1", err_last); end
        checks++; if (ar_hs_cnt !== 0) begin failures++; $display("FAIL zero_ar_count got=%0d expected=0", ar_hs_cnt); end

        apply_reset();
        total = 256;
        read_addr = 32'h0001_0000;
        read_num = 32'd300;
        kick = 1'b1;
        step();
        kick = 1'b0;
        checks++; if (m_axi_arlen !== 8'd255) begin failures++; $display("FAIL clamp_arlen got=%0d expected=255", m_axi_arlen); end
        checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL clamp_err_last got=%b expected=1", err_last); end
        wait_idle(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL clamp_timeout done=0 expected=1"); end
        checks++; if (px_count !== 256) begin failures++; $display("FAIL clamp_pixels got=%0d expected=256", px_count); end
    endtask

    task automatic test_protocol_errors();
        bit ok;
        apply_reset();
        total = 64;
        err_idx = 2;
        early_idx = 59;
        final_rlast = 1'b0;
        read_addr = 32'h0000_0100;
        read_num = 32'd64;
        kick = 1'b1;
        step();
        kick = 1'b0;
        wait_idle(1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL proto_timeout done=0 expected=1"); end
        checks++; if (err_resp !== 1'b1) begin failures++; $display("FAIL proto_err_resp got=%b expected=1", err_resp); end
        checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL proto_err_last got=%b expected=1", err_last); end
        checks++; if (px_count !== 64) begin failures++; $display("FAIL proto_pixels got=%0d expected=64", px_count); end
    endtask

    task automatic test_rlast_mismatch();
        bit ok;
        // Early RLAST, final beat correctly flagged
        apply_reset();
        total = 16;
        early_idx = 5;
        final_rlast = 1'b1;
        read_addr = 32'h0000_0200;
        read_num = 32'd16;
        kick = 1'b1;
        step();
        kick = 1'b0;
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL early_last_timeout done=0 expected=1"); end
        checks++; if (err_last !== 1'b1 || err_resp !== 1'b0) begin failures++; $display("FAIL early_last_flags got=%b%b expected=01", err_resp, err_last); end
        // RLAST missing on the final beat
        apply_reset();
        total = 16;
        early_idx = -1;
        final_rlast = 1'b0;
        kick = 1'b1;
        step();
        kick = 1'b0;
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL missing_last_timeout done=0 expected=1"); end
        checks++; if (err_last !== 1'b1 || err_resp !== 1'b0) begin failures++; $display("FAIL missing_last_flags got=%b%b expected=01", err_resp, err_last); end
        checks++; if (px_count !== 16) begin failures++; $display("FAIL missing_last_pixels got=%0d expected=16", px_count); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit hit;
        apply_reset();
        total = 64;
        err_idx = 1;
        read_addr = 32'h0000_0100;
        read_num = 32'd64;
        kick = 1'b1;
        step();
        kick = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (beats_acc >= 20) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin failures++; $display("FAIL midrst_reach got beats=%0d expected=20", beats_acc); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        px_count = 0;
        idle_next = 1'b0;
        ar_hs_cnt = 0;
        checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got busy=%b pix_valid=%b expected=0/0", busy, pix_valid); end
        checks++; if (err_resp !== 1'b0 || err_last !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b%b expected=00", err_resp, err_last); end
        checks++; if (m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0 || pix_data !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h/%0d/%h expected=0/0/0", m_axi_araddr, m_axi_arlen, pix_data); end
        total = 8;
        err_idx = -1;
        read_addr = 32'h0000_0300;
        read_num = 32'd8;
        kick = 1'b1;
        step();
        kick = 1'b0;
        checks++; if (busy !== 1'b1 || m_axi_araddr !== TB_BASE + 32'h300) begin failures++; $display("FAIL midrst_rekick got busy=%b araddr=%h expected=1/%h", busy, m_axi_araddr, TB_BASE + 32'h300); end
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout done=0 expected=1"); end
        checks++; if (px_count !== 8) begin failures++; $display("FAIL midrst_pixels got=%0d expected=8", px_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        apply_reset();
        total = 8;
        read_addr = 32'h0000_1000;
        read_num = 32'd8;
        kick = 1'b1;
        step();
        kick = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk_vga);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_first_timeout done=0 expected=1"); end
        // The address wraps modulo 2^32 once the base is added.
        read_addr = 32'hF000_2000;
        kick = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b expected=1", busy); end
        checks++; if (m_axi_araddr !== 32'h0000_2000) begin failures++; $display("FAIL b2b_araddr_wrap got=%h expected=00002000", m_axi_araddr); end
        kick = 1'b0;
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout done=0 expected=1"); end
        checks++; if (px_count !== 16) begin failures++; $display("FAIL b2b_pixels got=%0d expected=16", px_count); end
        checks++; if (ar_hs_cnt !== 2) begin failures++; $display("FAIL b2b_ar_count got=%0d expected=2", ar_hs_cnt); end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_slow_arready();
        test_boundary();
        test_protocol_errors();
        test_rlast_mismatch();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time_limit_reached expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
